// File: rtl/soc_pkg.sv
// Shared types and widths for the board-level SoC: UART state encoding and LED field layout.
package soc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

    localparam int unsigned LED_W     = 16;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned PAD_W     = 3;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_IDX_W = 3;

    // Counter width for a modulus n; never below one bit so n==1 still yields a legal vector.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-samples each bit, reports a good byte or a framing error for one cycle.
module uart_rx
    import soc_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              rx_valid,
    output logic              frame_err
);

    localparam int unsigned       CLK_W     = cnt_width(CLKS_PER_BIT);
    localparam logic [CLK_W-1:0]  BIT_LAST  = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CLK_W-1:0]  HALF_LAST = CLK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(BYTE_W - 1);

    uart_state_e          state, next_state;
    logic [CLK_W-1:0]     clk_cnt;
    logic [BIT_IDX_W-1:0] bit_idx;
    logic [BYTE_W-1:0]    shift;
    logic                 sample;
    logic                 byte_done;
    logic                 stop_err;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // START samples half a bit in, so every later sample lands on a bit centre.
    always_comb begin
        sample = 1'b0;
        case (state)
            START:      sample = (clk_cnt == HALF_LAST);
            DATA, STOP: sample = (clk_cnt == BIT_LAST);
            default:    sample = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (!rx) next_state = START;
            START:   if (sample) next_state = rx ? IDLE : DATA;
            DATA:    if (sample && (bit_idx == IDX_LAST)) next_state = STOP;
            STOP:    if (sample) next_state = rx ? IDLE : BREAK;
            BREAK:   if (rx) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        byte_done = (state == STOP) && sample && rx;
        stop_err  = (state == STOP) && sample && !rx;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= byte_done;
            frame_err <= stop_err;
            if (byte_done) rx_byte <= shift;

            if ((state != next_state) || sample || (state == IDLE) || (state == BREAK))
                clk_cnt <= '0;
            else
                clk_cnt <= clk_cnt + CLK_W'(1);

            if (state == IDLE) begin
                bit_idx <= '0;
            end else if ((state == DATA) && sample) begin
                shift   <= {rx, shift[BYTE_W-1:1]};
                bit_idx <= bit_idx + BIT_IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/soc.sv
// Board top: LED activity counter, UART receiver with switch-gated echo transmitter.
module soc
    import soc_pkg::*;
#(
    parameter int unsigned CNT_DIV      = 1,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [LED_W-1:0] sw,
    output logic [LED_W-1:0] led,
    input  logic             rx,
    output logic             tx
);

    localparam int unsigned          PRE_W    = cnt_width(CNT_DIV);
    localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(CNT_DIV - 1);
    localparam int unsigned          CLK_W    = cnt_width(CLKS_PER_BIT);
    localparam logic [CLK_W-1:0]     BIT_LAST = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(BYTE_W - 1);

    logic [1:0] rx_sync;
    logic [1:0] sw_sync;
    logic       rx_s;
    logic       echo_en;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rx_sync <= '1;
            sw_sync <= '0;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            sw_sync <= {sw_sync[0], sw[0]};
        end
    end

    assign rx_s    = rx_sync[1];
    assign echo_en = sw_sync[1];

    logic [BYTE_W-1:0] rx_byte;
    logic              rx_valid;
    logic              frame_err;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (CLK),
        .reset    (RESET),
        .rx       (rx_s),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .frame_err(frame_err)
    );

    logic unused_inputs;
    assign unused_inputs = ^{sw[LED_W-1:1], frame_err};

    logic [PRE_W-1:0] prescale;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             pre_wrap;

    always_comb begin
        pre_wrap = (prescale == PRE_LAST);
        cnt_next = pre_wrap ? cnt + CNT_W'(1) : cnt;
    end

    // led is built from next-state values so led[4:0] tracks cnt with no extra lag.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            prescale <= '0;
            cnt      <= '0;
            led      <= '0;
        end else begin
            prescale <= pre_wrap ? '0 : prescale + PRE_W'(1);
            cnt      <= cnt_next;
            led      <= {rx_byte, {PAD_W{1'b0}}, cnt_next};
        end
    end

    uart_state_e          tx_state, tx_next;
    logic [CLK_W-1:0]     tx_clk_cnt;
    logic [BIT_IDX_W-1:0] tx_bit_idx;
    logic [BYTE_W-1:0]    tx_shift;
    logic                 tx_load;
    logic                 tx_bit_end;
    logic                 tx_d;

    always_ff @(posedge CLK) begin
        if (!RESET) tx_state <= IDLE;
        else        tx_state <= tx_next;
    end

    // A byte arriving while TX is still in STOP (or with echo off) is dropped, not queued.
    always_comb begin
        tx_load    = rx_valid && echo_en && (tx_state == IDLE);
        tx_bit_end = (tx_clk_cnt == BIT_LAST);
        tx_next    = tx_state;
        unique case (tx_state)
            IDLE:    if (tx_load) tx_next = START;
            START:   if (tx_bit_end) tx_next = DATA;
            DATA:    if (tx_bit_end && (tx_bit_idx == IDX_LAST)) tx_next = STOP;
            STOP:    if (tx_bit_end) tx_next = IDLE;
            default: tx_next = IDLE;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        case (tx_state)
            START:   tx_d = 1'b0;
            DATA:    tx_d = tx_shift[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            tx_clk_cnt <= '0;
            tx_bit_idx <= '0;
            tx_shift   <= '0;
            tx         <= 1'b1;
        end else begin
            tx <= tx_d;
            if (tx_load) tx_shift <= rx_byte;

            if ((tx_state == IDLE) || tx_bit_end)
                tx_clk_cnt <= '0;
            else
                tx_clk_cnt <= tx_clk_cnt + CLK_W'(1);

            if (tx_state == IDLE) begin
                tx_bit_idx <= '0;
            end else if ((tx_state == DATA) && tx_bit_end) begin
                tx_shift   <= {1'b0, tx_shift[BYTE_W-1:1]};
                tx_bit_idx <= tx_bit_idx + BIT_IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_soc.sv
// Directed bench for soc: LED counter, UART receive/echo, framing errors and mid-frame reset.
module tb_soc;

    localparam int unsigned CLKS = 16;

    logic        CLK   = 1'b0;
    logic        RESET = 1'b0;
    logic [15:0] sw    = '0;
    logic [15:0] led;
    logic        rx    = 1'b1;
    logic        tx;

    int errors = 0;
    int checks = 0;

    soc #(
        .CNT_DIV     (1),
        .CLKS_PER_BIT(CLKS)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .sw   (sw),
        .led  (led),
        .rx   (rx),
        .tx   (tx)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CLKS);
        end
        rx = stop_bit;
        tick(CLKS);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        RESET = 1'b0;
        rx    = 1'b1;
        sw    = '0;
        tick(4);
        checks++;
        if (led !== 16'h0000) begin
            errors++;
            $display("FAIL reset_led: got %h expected %h", led, 16'h0000);
        end
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx: got %b expected %b", tx, 1'b1);
        end
        RESET = 1'b1;
        // 33 cycles: passes 5'h1F at cycle 31 and wraps to 0 at cycle 32.
        for (int i = 1; i <= 33; i++) begin
            tick(1);
            checks++;
            if (led[4:0] !== 5'(i)) begin
                errors++;
                $display("FAIL cnt_step%0d: got %h expected %h", i, led[4:0], 5'(i));
            end
            checks++;
            if (led[15:5] !== 11'h000) begin
                errors++;
                $display("FAIL led_upper%0d: got %h expected %h", i, led[15:5], 11'h000);
            end
        end
    endtask

    task automatic test_echo;
        logic [7:0] got;
        int         w;
        sw = 16'h0001;
        tick(4);
        got = '0;
        w   = 0;
        fork
            send_byte(8'hA5, 1'b1);
            begin
                while ((tx === 1'b1) && (w < 400)) begin
                    tick(1);
                    w++;
                end
                checks++;
                if (tx !== 1'b0) begin
                    errors++;
                    $display("FAIL echo_start_timeout: got tx=%b expected %b", tx, 1'b0);
                end else begin
                    tick(CLKS / 2);
                    checks++;
                    if (tx !== 1'b0) begin
                        errors++;
                        $display("FAIL echo_start_bit: got %b expected %b", tx, 1'b0);
                    end
                    for (int i = 0; i < 8; i++) begin
                        tick(CLKS);
                        got[i] = tx;
                    end
                    checks++;
                    if (got !== 8'hA5) begin
                        errors++;
                        $display("FAIL echo_data: got %h expected %h", got, 8'hA5);
                    end
                    tick(CLKS);
                    checks++;
                    if (tx !== 1'b1) begin
                        errors++;
                        $display("FAIL echo_stop_bit: got %b expected %b", tx, 1'b1);
                    end
                end
            end
        join
        tick(2 * CLKS);
        checks++;
        if (led[15:8] !== 8'hA5) begin
            errors++;
            $display("FAIL echo_led: got %h expected %h", led[15:8], 8'hA5);
        end
    endtask

    task automatic test_no_echo;
        logic low_seen;
        sw = 16'h0000;
        tick(4);
        low_seen = 1'b0;
        fork
            send_byte(8'h3C, 1'b1);
            begin
                for (int i = 0; i < 12 * CLKS; i++) begin
                    tick(1);
                    if (tx !== 1'b1) low_seen = 1'b1;
                end
            end
        join
        checks++;
        if (low_seen !== 1'b0) begin
            errors++;
            $display("FAIL no_echo_tx: got low_seen=%b expected %b", low_seen, 1'b0);
        end
        tick(4);
        checks++;
        if (led[15:8] !== 8'h3C) begin
            errors++;
            $display("FAIL no_echo_led: got %h expected %h", led[15:8], 8'h3C);
        end
    endtask

    task automatic test_break;
        logic tx_low;
        RESET = 1'b0;
        rx    = 1'b0;
        sw    = 16'h0001;
        tick(3);
        RESET  = 1'b1;
        tx_low = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            tick(1);
            if (tx !== 1'b1) tx_low = 1'b1;
        end
        checks++;
        if (tx_low !== 1'b0) begin
            errors++;
            $display("FAIL break_tx: got low_seen=%b expected %b", tx_low, 1'b0);
        end
        checks++;
        if (led[15:8] !== 8'h00) begin
            errors++;
            $display("FAIL break_led: got %h expected %h", led[15:8], 8'h00);
        end
        checks++;
        if (led[4:0] !== 5'd12) begin
            errors++;
            $display("FAIL break_cnt: got %h expected %h", led[4:0], 5'd12);
        end
    endtask

    task automatic test_frame_err;
        sw = 16'h0000;
        rx = 1'b1;
        tick(CLKS);
        send_byte(8'h55, 1'b0);
        tick(CLKS);
        checks++;
        if (led[15:8] !== 8'h00) begin
            errors++;
            $display("FAIL frame_err_discard: got %h expected %h", led[15:8], 8'h00);
        end
        send_byte(8'h0F, 1'b1);
        tick(4);
        checks++;
        if (led[15:8] !== 8'h0F) begin
            errors++;
            $display("FAIL frame_err_recover: got %h expected %h", led[15:8], 8'h0F);
        end
    endtask

    task automatic test_reset_mid_tx;
        int   w;
        logic tx_low;
        sw = 16'h0001;
        tick(4);
        send_byte(8'h81, 1'b1);
        w = 0;
        while ((tx === 1'b1) && (w < 40)) begin
            tick(1);
            w++;
        end
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL midtx_frame_started: got tx=%b expected %b", tx, 1'b0);
        end
        tick(2 * CLKS);
        RESET = 1'b0;
        tick(1);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL midtx_reset_tx: got %b expected %b", tx, 1'b1);
        end
        checks++;
        if (led !== 16'h0000) begin
            errors++;
            $display("FAIL midtx_reset_led: got %h expected %h", led, 16'h0000);
        end
        tick(1);
        RESET  = 1'b1;
        tx_low = 1'b0;
        for (int i = 0; i < 15 * CLKS; i++) begin
            tick(1);
            if (tx !== 1'b1) tx_low = 1'b1;
        end
        checks++;
        if (tx_low !== 1'b0) begin
            errors++;
            $display("FAIL midtx_no_resume: got low_seen=%b expected %b", tx_low, 1'b0);
        end
        checks++;
        if (led[15:8] !== 8'h00) begin
            errors++;
            $display("FAIL midtx_led_byte: got %h expected %h", led[15:8], 8'h00);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_echo;
        test_no_echo;
        test_break;
        test_frame_err;
        test_reset_mid_tx;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
